// File: rtl/soc_loader_pkg.sv
// Shared types and sizes for the boot-time SPI-to-ICCM loader.
// The FSM encoding is shared so the top and any debug logic agree on it.
package soc_loader_pkg;

   localparam int LOADER_DATA_WIDTH = 32;
   localparam int LOADER_ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/spi_rx_shifter.sv
// MSB-first deserializer: shift register, bit counter, word-complete and
// truncated-frame detection. Frame sequencing is owned by the parent.
module spi_rx_shifter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  frame_i,
   input  logic                  kill_i,
   input  logic                  ss_i,
   input  logic                  mosi_i,
   output logic [DATA_WIDTH-1:0] shreg_o,
   output logic                  last_o,
   output logic                  trunc_o,
   output logic                  word_valid_o
);

   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  word_valid_q, word_valid_d;
   logic                  shift;

   always_comb begin
      shift   = frame_i & ~ss_i & ~kill_i;
      last_o  = shift & (bit_cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
      trunc_o = frame_i & ss_i & ~kill_i &
                (bit_cnt_q != '0) &
                (bit_cnt_q < CNT_WIDTH'(DATA_WIDTH));
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      word_valid_d = last_o;
      if (start_i) begin
         shreg_d   = {shreg_q[DATA_WIDTH-2:0], mosi_i};
         bit_cnt_d = CNT_WIDTH'(1);
      end else if (frame_i & (kill_i | ss_i)) begin
         // partial word is dropped, whether truncated or cut off by en_i
         shreg_d   = '0;
         bit_cnt_d = '0;
      end else if (shift) begin
         shreg_d   = {shreg_q[DATA_WIDTH-2:0], mosi_i};
         bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         word_valid_q <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign shreg_o      = shreg_q;
   assign word_valid_o = word_valid_q;

endmodule

// File: rtl/spi_iccm_loader.sv
// SPI-slave boot loader: streams 32-bit words into ICCM and holds the
// core in load mode until en_i hands control over.
module spi_iccm_loader
   import soc_loader_pkg::*;
#(
   parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
   parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  sel,
   input  logic                  spi_ss,
   input  logic                  spi_mosi,
   output logic                  iccm_cntrl_reset,
   output logic                  iccm_cntrl_we,
   output logic [ADDR_WIDTH-1:0] iccm_cntrl_addr,
   output logic [DATA_WIDTH-1:0] iccm_cntrl_data,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  frame_err,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

   loader_state_e         state_q, state_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overflow_q, overflow_d;
   logic                  cntrl_reset_q, cntrl_reset_d;
   logic                  load_done_q, load_done_d;

   logic                  start, frame;
   logic                  last, trunc, word_valid;
   logic [DATA_WIDTH-1:0] shreg;

   assign start = (state_q == IDLE) & ~spi_ss & ~sel & ~en_i;
   assign frame = (state_q == SHIFT);

   spi_rx_shifter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shifter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start),
      .frame_i      (frame),
      .kill_i       (en_i),
      .ss_i         (spi_ss),
      .mosi_i       (spi_mosi),
      .shreg_o      (shreg),
      .last_o       (last),
      .trunc_o      (trunc),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = DONE;
      end else begin
         unique case (state_q)
            IDLE:  if (!spi_ss && !sel) state_d = SHIFT;
            SHIFT: begin
               if (spi_ss)    state_d = IDLE;
               else if (last) state_d = HOLD;
            end
            HOLD:  if (spi_ss) state_d = IDLE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      we_d          = 1'b0;
      addr_d        = addr_q;
      data_d        = data_q;
      overflow_d    = overflow_q;
      wr_ptr_d      = wr_ptr_q;
      word_count_d  = word_count_q;
      frame_err_d   = frame_err_q | trunc;
      cntrl_reset_d = cntrl_reset_q & (state_q != DONE);
      load_done_d   = load_done_q | (state_q == DONE);
      if (word_valid) begin
         if (word_count_q == CAP) begin
            overflow_d = 1'b1;
         end else begin
            we_d   = 1'b1;
            addr_d = wr_ptr_q;
            data_d = shreg;
         end
      end
      // the pointer parks on the last word instead of wrapping to 0
      if (we_q) begin
         word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
         if (wr_ptr_q != '1) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         wr_ptr_q      <= '0;
         word_count_q  <= '0;
         frame_err_q   <= 1'b0;
         overflow_q    <= 1'b0;
         cntrl_reset_q <= 1'b1;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         wr_ptr_q      <= wr_ptr_d;
         word_count_q  <= word_count_d;
         frame_err_q   <= frame_err_d;
         overflow_q    <= overflow_d;
         cntrl_reset_q <= cntrl_reset_d;
         load_done_q   <= load_done_d;
      end
   end

   assign iccm_cntrl_reset = cntrl_reset_q;
   assign iccm_cntrl_we    = we_q;
   assign iccm_cntrl_addr  = addr_q;
   assign iccm_cntrl_data  = data_q;
   assign load_done        = load_done_q;
   assign word_count       = word_count_q;
   assign frame_err        = frame_err_q;
   assign overflow         = overflow_q;

endmodule

// File: tb/tb_spi_iccm_loader.sv
// Directed + randomized bench for spi_iccm_loader; a 4096-word and a
// 4-word instance share the SPI inputs and each has its own write model.
module tb_spi_iccm_loader;

   typedef struct {
      int          cyc;
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n, en, sel, ss, mosi;

   logic        ccr_a, we_a, done_a, ferr_a, ovf_a;
   logic [11:0] addr_a;
   logic [31:0] data_a;
   logic [12:0] wc_a;

   logic        ccr_b, we_b, done_b, ferr_b, ovf_b;
   logic [1:0]  addr_b;
   logic [31:0] data_b;
   logic [2:0]  wc_b;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   wr_t exp_a[$], exp_b[$], got_a[$], got_b[$];
   int  cnt_m[2];
   int  cap_m[2];
   bit  ovf_m[2];
   bit  ferr_m, done_m;
   int  last_k;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_iccm_loader dut_a (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .en_i             (en),
      .sel              (sel),
      .spi_ss           (ss),
      .spi_mosi         (mosi),
      .iccm_cntrl_reset (ccr_a),
      .iccm_cntrl_we    (we_a),
      .iccm_cntrl_addr  (addr_a),
      .iccm_cntrl_data  (data_a),
      .load_done        (done_a),
      .word_count       (wc_a),
      .frame_err        (ferr_a),
      .overflow         (ovf_a)
   );

   spi_iccm_loader #(.ADDR_WIDTH(2)) dut_b (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .en_i             (en),
      .sel              (sel),
      .spi_ss           (ss),
      .spi_mosi         (mosi),
      .iccm_cntrl_reset (ccr_b),
      .iccm_cntrl_we    (we_b),
      .iccm_cntrl_addr  (addr_b),
      .iccm_cntrl_data  (data_b),
      .load_done        (done_b),
      .word_count       (wc_b),
      .frame_err        (ferr_b),
      .overflow         (ovf_b)
   );

   always @(negedge clk) begin
      if (we_a === 1'b1) got_a.push_back('{cyc, int'(addr_a), data_a});
      if (we_b === 1'b1) got_b.push_back('{cyc, int'(addr_b), data_b});
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_a.delete(); exp_b.delete();
      got_a.delete(); got_b.delete();
      cnt_m = '{0, 0};
      ovf_m = '{0, 0};
      ferr_m = 0;
      done_m = 0;
   endtask

   // a completed word goes to the next free address unless loading ended
   // or that instance is already full
   task automatic model_word(input logic [31:0] w, input int t);
      if (!done_m) begin
         if (cnt_m[0] < cap_m[0]) begin
            exp_a.push_back('{t, cnt_m[0], w});
            cnt_m[0]++;
         end else ovf_m[0] = 1;
         if (cnt_m[1] < cap_m[1]) begin
            exp_b.push_back('{t, cnt_m[1], w});
            cnt_m[1]++;
         end else ovf_m[1] = 1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ccr"}, ccr_a, 1);
      chk({tag, "_we"}, we_a, 0);
      chk({tag, "_addr"}, addr_a, 0);
      chk({tag, "_data"}, data_a, 0);
      chk({tag, "_done"}, done_a, 0);
      chk({tag, "_wc"}, wc_a, 0);
      chk({tag, "_ferr"}, ferr_a, 0);
      chk({tag, "_ovf"}, ovf_a, 0);
      chk({tag, "_wc_b"}, wc_b, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 0; en = 0; sel = 0; ss = 1; mosi = 0;
      repeat (2) @(negedge clk);
      chk_reset_vals(tag);
      rst_n = 1;
      model_clear();
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ss = 0;
         mosi = w[31-i];
         last_k = cyc;
      end
   endtask

   task automatic finish_frame(input int extra, input int gap);
      @(negedge clk);
      mosi = 0;
      for (int i = 0; i < extra; i++) begin
         @(negedge clk);
         mosi = 1'($urandom);
      end
      @(negedge clk);
      ss = 1;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic frame(input logic [31:0] w, input int extra, input int gap);
      send_bits(w, 32);
      model_word(w, last_k + 2);
      finish_frame(extra, gap);
   endtask

   task automatic compare(input string tag);
      wr_t e, g;
      @(negedge clk);
      chk({tag, "_nwr_a"}, got_a.size(), exp_a.size());
      while (exp_a.size() > 0 && got_a.size() > 0) begin
         e = exp_a.pop_front(); g = got_a.pop_front();
         chk({tag, "_addr_a"}, g.addr, e.addr);
         chk({tag, "_data_a"}, g.data, e.data);
         chk({tag, "_cyc_a"}, g.cyc, e.cyc);
      end
      chk({tag, "_nwr_b"}, got_b.size(), exp_b.size());
      while (exp_b.size() > 0 && got_b.size() > 0) begin
         e = exp_b.pop_front(); g = got_b.pop_front();
         chk({tag, "_addr_b"}, g.addr, e.addr);
         chk({tag, "_data_b"}, g.data, e.data);
      end
      exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
      chk({tag, "_wc_a"}, wc_a, cnt_m[0]);
      chk({tag, "_wc_b"}, wc_b, cnt_m[1]);
      chk({tag, "_ferr"}, ferr_a, ferr_m);
      chk({tag, "_ovf_a"}, ovf_a, ovf_m[0]);
      chk({tag, "_ovf_b"}, ovf_b, ovf_m[1]);
      chk({tag, "_ccr"}, ccr_a, !done_m);
      chk({tag, "_done"}, done_a, done_m);
   endtask

   initial begin
      logic [31:0] w;
      cap_m = '{4096, 4};
      rst_n = 1; en = 0; sel = 0; ss = 1; mosi = 0;
      model_clear();

      do_reset("rst0");
      frame(32'h00500093, 0, 4);
      compare("single");

      frame(32'hDEADBEEF, 0, 4);
      frame(32'h12345678, 0, 4);
      frame(32'hFFFFFFFF, 0, 4);
      compare("b2b");

      for (int i = 0; i < 4; i++)
         frame($urandom, $urandom_range(0, 3), $urandom_range(2, 6));
      compare("rand");

      do_reset("rst1");
      send_bits(32'h13579BDF, 17);
      @(negedge clk);
      ss = 1;
      ferr_m = 1;
      repeat (2) @(negedge clk);
      frame(32'hCAFEF00D, 1, 3);
      compare("trunc");

      do_reset("rst2");
      for (int i = 0; i < 5; i++)
         frame($urandom, $urandom_range(0, 2), $urandom_range(2, 5));
      compare("ovf");

      do_reset("rst3");
      sel = 1;
      send_bits(32'hA5A5A5A5, 32);
      finish_frame(0, 3);
      sel = 0;
      compare("selblk");
      w = $urandom;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ss = 0;
         mosi = w[31-i];
         if (i == 3) sel = 1;
         last_k = cyc;
      end
      model_word(w, last_k + 2);
      finish_frame(0, 3);
      sel = 0;
      compare("selmid");

      do_reset("rst4");
      frame($urandom, 0, 3);
      frame($urandom, 0, 3);
      compare("pre_en");
      en = 1;
      @(negedge clk);
      chk("en_ccr_t1", ccr_a, 1);
      chk("en_done_t1", done_a, 0);
      @(negedge clk);
      chk("en_ccr_t2", ccr_a, 0);
      chk("en_done_t2", done_a, 1);
      done_m = 1;
      frame($urandom, 0, 3);
      compare("post_en");

      do_reset("rst5");
      w = $urandom;
      send_bits(w, 32);
      model_word(w, last_k + 2);
      @(negedge clk);
      en = 1;
      done_m = 1;
      finish_frame(0, 3);
      compare("en_pend");

      do_reset("rst6");
      send_bits($urandom, 10);
      @(negedge clk);
      en = 1;
      done_m = 1;
      repeat (2) @(negedge clk);
      ss = 1;
      repeat (2) @(negedge clk);
      compare("en_part");

      do_reset("rst7");
      frame($urandom, 0, 3);
      frame($urandom, 0, 3);
      compare("pre_arst");
      send_bits($urandom, 20);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk_reset_vals("arst");
      @(negedge clk);
      ss = 1;
      @(negedge clk);
      rst_n = 1;
      model_clear();
      frame(32'h0000005A, 0, 3);
      compare("post_arst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
